// File: rtl/vibration_defs_pkg.sv
// Shared definitions for the vibration-count front end: state encoding,
// 50 MHz default timing constants and the glitch counter width.
package vibration_defs_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUALIFY = 2'd1,
        PULSE   = 2'd2,
        LOCKOUT = 2'd3
    } vib_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;   // 1 ms
    localparam int unsigned DEF_PULSE_CYCLES    = 4;
    localparam int unsigned DEF_LOCKOUT_CYCLES  = 500000;  // 10 ms
    localparam int unsigned DEF_CNT_W           = 20;

    localparam int unsigned GLITCH_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser for asynchronous board inputs,
// asynchronous active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vibration_conditioner.sv
// Debounces the raw vibration contact and emits one fixed-width, glitch-free
// `up` pulse per genuine event, followed by a lockout period.
module vibration_conditioner
    import vibration_defs_pkg::*;
#(
    parameter bit          POLARITY        = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int unsigned LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sens_raw,
    input  logic                enable,
    output logic                up,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCKOUT_CYCLES - 1);

    vib_state_t       state, state_next;
    logic [CNT_W-1:0] tmr, tmr_next;
    logic             sync_q;
    logic             s;
    logic             glitch_inc;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sens_raw),
        .q   (sync_q)
    );

    assign s = ~(sync_q ^ POLARITY);

    always_comb begin
        state_next = state;
        tmr_next   = tmr;
        glitch_inc = 1'b0;
        case (state)
            IDLE: begin
                if (enable && s) state_next = QUALIFY;
            end
            QUALIFY: begin
                // Enable abort takes priority over a dropped contact.
                if (!enable) begin
                    state_next = IDLE;
                end else if (!s) begin
                    state_next = IDLE;
                    glitch_inc = 1'b1;
                end else if (tmr == DEB_LAST) begin
                    state_next = PULSE;
                end else begin
                    tmr_next = tmr + 1'b1;
                end
            end
            PULSE: begin
                if (tmr == PULSE_LAST) state_next = LOCKOUT;
                else                   tmr_next   = tmr + 1'b1;
            end
            LOCKOUT: begin
                if (tmr == LOCK_LAST) begin
                    if (!s) state_next = IDLE;
                end else begin
                    tmr_next = tmr + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_next != state) tmr_next = '0;
    end

    // up/busy come from next-state so they are clean registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tmr        <= '0;
            up         <= 1'b0;
            busy       <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            state <= state_next;
            tmr   <= tmr_next;
            up    <= (state_next == PULSE);
            busy  <= (state_next != IDLE);
            if (glitch_inc && (glitch_cnt != '1))
                glitch_cnt <= glitch_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_vibration_conditioner.sv
// Scoreboard bench: stimulus pushes expected up-pulses (rise edge, width),
// a negedge monitor pops and compares on every falling edge of up.
module tb_vibration_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       raw = 1'b0;
    logic       raw_n = 1'b1;
    logic       enable = 1'b1;
    logic       up, busy, up_n, busy_n;
    logic [7:0] glitch_cnt, glitch_cnt_n;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int ch;
        int rise;
        int width;
    } exp_t;
    exp_t sb[$];

    vibration_conditioner #(
        .POLARITY(1'b1), .DEBOUNCE_CYCLES(8), .PULSE_CYCLES(4),
        .LOCKOUT_CYCLES(16), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .sens_raw(raw), .enable(enable),
        .up(up), .busy(busy), .glitch_cnt(glitch_cnt)
    );

    vibration_conditioner #(
        .POLARITY(1'b0), .DEBOUNCE_CYCLES(8), .PULSE_CYCLES(4),
        .LOCKOUT_CYCLES(16), .CNT_W(8)
    ) dut_n (
        .clk(clk), .rst(rst), .sens_raw(raw_n), .enable(enable),
        .up(up_n), .busy(busy_n), .glitch_cnt(glitch_cnt_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: measure each up pulse, compare against scoreboard on its fall.
    bit prev[2];
    int rise_c[2];
    int wid[2];
    always @(negedge clk) begin : monitor
        bit u;
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            u = (c == 0) ? up : up_n;
            if (u && !prev[c]) begin
                rise_c[c] = cyc;
                wid[c] = 1;
            end else if (u) begin
                wid[c]++;
            end else if (prev[c]) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse ch%0d: got rise=%0d width=%0d, expected no pulse",
                             c, rise_c[c], wid[c]);
                end else begin
                    e = sb.pop_front();
                    if (e.ch != c || e.rise != rise_c[c] || e.width != wid[c]) begin
                        errors++;
                        $display("FAIL pulse: got ch%0d rise=%0d width=%0d, expected ch%0d rise=%0d width=%0d",
                                 c, rise_c[c], wid[c], e.ch, e.rise, e.width);
                    end
                end
            end
            prev[c] = u;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int ch, input int rise, input int width);
        exp_t e;
        e.ch = ch;
        e.rise = rise;
        e.width = width;
        sb.push_back(e);
    endtask

    initial begin
        int c0;
        int r;

        // Reset state
        tick(3);
        chk("reset_up", int'(up), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_glitch", int'(glitch_cnt), 0);
        rst = 1'b0;
        tick(10);

        // Clean press: up from edge 10 to 14 relative to first sampling edge
        c0 = cyc;
        push(0, c0 + 11, 4);
        raw = 1'b1;
        tick(25);
        chk("clean_busy_mid", int'(busy), 1);
        tick(15);
        raw = 1'b0;
        tick(2);
        chk("clean_busy_before_idle", int'(busy), 1);
        tick(1);
        chk("clean_busy_idle", int'(busy), 0);
        chk("clean_glitch", int'(glitch_cnt), 0);
        tick(10);

        // Polarity 0: same timing on the inverted-input instance
        c0 = cyc;
        push(1, c0 + 11, 4);
        raw_n = 1'b0;
        tick(40);
        raw_n = 1'b1;
        tick(2);
        chk("pol0_busy_before_idle", int'(busy_n), 1);
        tick(1);
        chk("pol0_busy_idle", int'(busy_n), 0);
        tick(10);

        // Bounce: three 3-cycle glitches, each counted 2 cycles after release
        for (int i = 0; i < 3; i++) begin
            raw = 1'b1;
            tick(3);
            raw = 1'b0;
            tick(2);
            chk("bounce_glitch_before", int'(glitch_cnt), i);
            tick(1);
            chk("bounce_glitch_after", int'(glitch_cnt), i + 1);
            tick(2);
        end
        c0 = cyc;
        push(0, c0 + 11, 4);
        raw = 1'b1;
        tick(30);
        raw = 1'b0;
        tick(40);
        chk("bounce_glitch_total", int'(glitch_cnt), 3);

        // Enable low: no pulse, glitch count untouched
        enable = 1'b0;
        raw = 1'b1;
        tick(40);
        raw = 1'b0;
        tick(10);
        chk("en_off_glitch", int'(glitch_cnt), 3);
        chk("en_off_busy", int'(busy), 0);
        enable = 1'b1;
        tick(5);

        // Enable dropped during PULSE: still full width
        c0 = cyc;
        push(0, c0 + 11, 4);
        raw = 1'b1;
        tick(13);
        enable = 1'b0;
        tick(27);
        raw = 1'b0;
        tick(40);
        enable = 1'b1;
        tick(5);

        // Held contact: one pulse, IDLE 2 cycles after release propagates
        c0 = cyc;
        push(0, c0 + 11, 4);
        raw = 1'b1;
        tick(200);
        chk("held_busy_lockout", int'(busy), 1);
        raw = 1'b0;
        tick(2);
        chk("held_busy_before_idle", int'(busy), 1);
        tick(1);
        chk("held_busy_idle", int'(busy), 0);
        tick(10);

        // Reset during PULSE: up drops at once, full qualify on release
        c0 = cyc;
        push(0, c0 + 11, 1);
        raw = 1'b1;
        tick(12);
        chk("rst_mid_up_before", int'(up), 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_up", int'(up), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_glitch", int'(glitch_cnt), 0);
        tick(2);
        r = cyc;
        push(0, r + 11, 4);
        rst = 1'b0;
        tick(10);
        chk("rst_release_no_early_up", int'(up), 0);
        tick(20);
        raw = 1'b0;
        tick(40);

        // Saturation: 300 short glitches
        for (int i = 0; i < 300; i++) begin
            raw = 1'b1;
            tick(3);
            raw = 1'b0;
            tick(5);
        end
        tick(5);
        chk("glitch_saturated", int'(glitch_cnt), 255);
        chk("sat_busy", int'(busy), 0);

        tick(20);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
